sw_readout_controller: RTL
==========================

// Module: sw_readout_controller
// PURPOSE
//  Sequences the load/read handshake of the pixel switch-cell readout chain.
//  - Counts pending L1 triggers.
//  - Issues one load per triggered event into the SW network, then drains hits with read while the chain reports unreadHit.
//  - Sits between the L1A source and the bottom (dn) port of the switch-cell chain; its pending counter replaces the L1 overflow buffer.
// PARAMETERS
//  L1_DEPTH     8   max pending (triggered, not yet loaded) events
//  SETTLE_CYC   2   idle cycles after load before unreadHit is sampled (>=1)
//  TIMEOUT_CYC  64  max consecutive SCAN cycles with unreadHit high (macro only)
// PORTS
//  clk            in   1   40 MHz clock
//  reset          in   1   synchronous, active-high reset
//  L1A            in   1   trigger accept pulse, one event per high cycle
//  unreadHit      in   1   chain still holds unread hit data for current event
//  enable         in   1   permit starting new events
//  load           out  1   one-cycle load strobe to SW chain
//  read           out  1   read strobe to SW chain
//  busy           out  1   state != IDLE
//  pendingCount   out  $clog2(L1_DEPTH+1)  events waiting for load
//  empty          out  1   pendingCount == 0
//  full           out  1   pendingCount == L1_DEPTH
//  eventDone      out  1   one-cycle pulse, event fully drained
//  eventHits      out  8   hits read for last completed event, valid with eventDone
//  overflowCount  out  8   L1A dropped while full, saturates at 255
//  timeoutErr     out  1   sticky read-timeout flag
// BEHAVIOUR
//  - Reset (sync, any state): IDLE; all counters 0; load/read/eventDone/timeoutErr/busy 0; empty 1; full 0.
//  - Pending counter:
//    - L1A && !full: +1.
//    - Load cycle: -1.
//    - L1A and load in the same cycle: count unchanged; accepted even when full.
//    - L1A while full with no load: dropped; overflowCount +1, saturating at 255.
//  - FSM:
//    - IDLE: enable && pendingCount>0 -> LOAD.
//    - LOAD: load=1 for exactly this cycle; hit counter cleared -> SETTLE.
//    - SETTLE: wait SETTLE_CYC cycles, ignore unreadHit -> SCAN.
//    - SCAN:
//      - read = unreadHit combinationally, qualified by state==SCAN; glitch-free, both terms are synchronous.
//      - Each cycle with read=1: hit counter +1, saturating at 255.
//      - unreadHit low: eventDone=1 next cycle; eventHits <= hit counter -> IDLE.
//  - Timing: load-to-first-possible-read latency = 1+SETTLE_CYC cycles.
//  - Back-to-back events: earliest load = 1 cycle after eventDone.
//  - enable low: in-flight event completes normally; no new LOAD from IDLE.
//  - unreadHit high in IDLE/LOAD/SETTLE: ignored; read stays 0.
//  - Registered outputs: load, eventDone, eventHits, counters, flags.
// CONFIGURATION
//  SWRO_READ_TIMEOUT_EN
//  - Defined:
//    - SCAN counts consecutive cycles.
//    - At TIMEOUT_CYC cycles with unreadHit still high: abort; timeoutErr set sticky until reset; eventDone pulses with eventHits=TIMEOUT_CYC (saturated); -> IDLE.
//  - Undefined: no watchdog; SCAN unbounded; timeoutErr tied 0.
// TESTING
//  - Reset mid-SCAN with read active:
//    - next cycle read=0, busy=0, pendingCount=0, overflowCount=0.
//  - One L1A; enable=1; chain holds 3 hits:
//    - load 1 cycle; read high 3 cycles starting 3 cycles after load.
//    - eventDone with eventHits=3; pendingCount back to 0.
//  - 10 L1A pulses while enable=0 (L1_DEPTH=8):
//    - full=1; pendingCount=8; overflowCount=2.
//    - Raise enable: 8 loads, 8 eventDone pulses, empty=1 at end.
//  - pendingCount=8; L1A coincides with a load cycle:
//    - count stays 8; overflowCount unchanged.
//  - Event with 0 hits (unreadHit low after settle):
//    - eventDone 1+SETTLE_CYC+1 cycles after load; eventHits=0; read never high.
//  - With SWRO_READ_TIMEOUT_EN, unreadHit stuck high:
//    - read high exactly 64 cycles; timeoutErr=1; FSM returns to IDLE.
//  - Without the macro: read stays high; timeoutErr=0.

Source files
------------

// File: rtl/sw_readout_controller.sv
// sw_readout_controller
//   Sequences the load/read handshake on the bottom (dn) port of the pixel
//   switch-cell readout chain. A small pending counter stands in for the L1
//   overflow buffer. For each pending event the controller issues one load,
//   waits for the chain to settle, and then reads hits for as long as the
//   chain reports unreadHit.
//
// Parameters
//   L1_DEPTH     max pending (triggered, not yet loaded) events
//   SETTLE_CYC   idle cycles after load before unreadHit is sampled (>=1)
//   TIMEOUT_CYC  max consecutive SCAN read cycles (watchdog build only)
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   L1A            trigger accept pulse, one event per high cycle
//   unreadHit      chain still holds unread hits for the current event
//   enable         permit starting new events
//   load           one-cycle load strobe to the chain (registered)
//   read           read strobe to the chain (unreadHit gated by SCAN)
//   busy           FSM not idle
//   pendingCount   events waiting for load
//   empty / full   pendingCount == 0 / == L1_DEPTH (registered)
//   eventDone      one-cycle pulse when an event is fully drained
//   eventHits      hits read for the last event, valid with eventDone
//   overflowCount  L1A dropped while full, saturating at 255
//   timeoutErr     sticky read-timeout flag
//
// Build option
//   SWRO_READ_TIMEOUT_EN  enables the SCAN watchdog; otherwise SCAN is
//                         unbounded and timeoutErr is tied low.
module sw_readout_controller #(
  parameter int L1_DEPTH    = 8,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 64,
  localparam int CW = $clog2(L1_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          L1A,
  input  logic          unreadHit,
  input  logic          enable,
  output logic          load,
  output logic          read,
  output logic          busy,
  output logic [CW-1:0] pendingCount,
  output logic          empty,
  output logic          full,
  output logic          eventDone,
  output logic [7:0]    eventHits,
  output logic [7:0]    overflowCount,
  output logic          timeoutErr
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  if (L1_DEPTH < 1 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : gBadParam
    $error("sw_readout_controller: L1_DEPTH, SETTLE_CYC and TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, SCAN} state_t;

  state_t          state;
  logic [SW-1:0]   settleCnt;
  logic [7:0]      hitCnt;
  logic [7:0]      hitNext;
  logic            accept;
  logic            drop;
  logic [CW-1:0]   pendNext;

  // Both terms are register outputs or synchronous inputs, so the strobe
  // cannot glitch within a cycle.
  assign read = unreadHit && (state == SCAN);
  assign busy = (state != IDLE);

  assign hitNext = (hitCnt == 8'hFF) ? hitCnt : hitCnt + 8'd1;

  // load is high exactly in the LOAD cycle, so it doubles as the decrement.
  // A trigger on the load cycle always fits, even when full.
  assign accept = L1A && (!full || load);
  assign drop   = L1A && full && !load;

  always_comb begin
    pendNext = pendingCount;
    if (accept && !load)
      pendNext = pendingCount + CW'(1);
    else if (!accept && load)
      pendNext = pendingCount - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pendingCount  <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      overflowCount <= '0;
    end else begin
      pendingCount <= pendNext;
      empty        <= (pendNext == '0);
      full         <= (pendNext == CW'(L1_DEPTH));
      if (drop && overflowCount != 8'hFF)
        overflowCount <= overflowCount + 8'd1;
    end
  end

`ifdef SWRO_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] scanCnt;
  logic          timeoutFlag;
  assign timeoutErr = timeoutFlag;
`else
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      load      <= 1'b0;
      eventDone <= 1'b0;
      eventHits <= '0;
      hitCnt    <= '0;
      settleCnt <= '0;
`ifdef SWRO_READ_TIMEOUT_EN
      scanCnt     <= '0;
      timeoutFlag <= 1'b0;
`endif
    end else begin
      load      <= 1'b0;
      eventDone <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && pendingCount != '0) begin
            state <= LOAD;
            load  <= 1'b1;
          end
        end
        LOAD: begin
          hitCnt    <= '0;
          settleCnt <= '0;
`ifdef SWRO_READ_TIMEOUT_EN
          scanCnt   <= '0;
`endif
          state     <= SETTLE;
        end
        SETTLE: begin
          // unreadHit is not trusted until the chain has settled
          if (settleCnt == SW'(SETTLE_CYC - 1))
            state <= SCAN;
          else
            settleCnt <= settleCnt + SW'(1);
        end
        SCAN: begin
          if (!unreadHit) begin
            eventDone <= 1'b1;
            eventHits <= hitCnt;
            state     <= IDLE;
          end else begin
            hitCnt <= hitNext;
`ifdef SWRO_READ_TIMEOUT_EN
            // This cycle is the last permitted read: report the event with
            // the hits read so far (including this one) and give up.
            if (scanCnt == TW'(TIMEOUT_CYC - 1)) begin
              timeoutFlag <= 1'b1;
              eventDone   <= 1'b1;
              eventHits   <= hitNext;
              state       <= IDLE;
            end else begin
              scanCnt <= scanCnt + TW'(1);
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
